// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM elastic pipeline stage.
//   stage_state_e : occupancy of the two-entry stage (empty, main only, main + skid)
//   CTRL_*        : bit positions of the named control bits carried with each beat
package ex_mem_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  localparam int CTRL_MEMWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_REGWRITE = 2;

endpackage

// File: rtl/ex_mem_pipe_entry.sv
// One payload register of the EX/MEM stage: data lanes, destination register
// and control bits, loaded together under a single enable.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low clear (payload returns to zero)
//   load_i   : capture data_i/rd_i/ctrl_i on the next rising edge
//   data_i/o : packed data lanes
//   rd_i/o   : destination register index
//   ctrl_i/o : control bits
module pipe_entry #(
  parameter int DATA_W = 64,
  parameter int LANES  = 3,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [LANES*DATA_W-1:0] data_i,
  input  logic [RD_W-1:0]         rd_i,
  input  logic [CTRL_W-1:0]       ctrl_i,
  output logic [LANES*DATA_W-1:0] data_o,
  output logic [RD_W-1:0]         rd_o,
  output logic [CTRL_W-1:0]       ctrl_o
);

  logic [LANES*DATA_W-1:0] data_q;
  logic [RD_W-1:0]         rd_q;
  logic [CTRL_W-1:0]       ctrl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      rd_q   <= '0;
      ctrl_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
      rd_q   <= rd_i;
      ctrl_q <= ctrl_i;
    end
  end

  assign data_o = data_q;
  assign rd_o   = rd_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/ex_mem_elastic_stage.sv
// EX/MEM pipeline stage with valid/ready handshake and a two-entry skid buffer.
// The main entry is always the one presented downstream; the skid entry catches
// the single beat accepted in the cycle downstream stalls, so in_ready can be a
// pure decode of registered state.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_EMPTY | nothing held, out_valid=0, in_ready=1
//   ST_ONE   | main holds a beat, out_valid=1, in_ready=1
//   ST_TWO   | main and skid hold beats, in_ready=0
//
// Ports:
//   clk, reset           : clock; asynchronous active-low reset
//   flush                : synchronous discard of all held beats and the offered beat
//   in_valid/in_ready    : upstream handshake
//   in_data/in_rd/in_ctrl: upstream payload (lane i at [i*DATA_W +: DATA_W])
//   out_valid/out_ready  : downstream handshake
//   out_data/out_rd      : presented payload (stale while out_valid=0)
//   out_ctrl             : presented control bits, forced to zero on a bubble
//   stall_cnt            : saturating count of cycles with out_valid=1, out_ready=0
module ex_mem_elastic_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int LANES       = 3,
  parameter int RD_W        = 5,
  parameter int CTRL_W      = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]         in_rd,
  input  logic [CTRL_W-1:0]       in_ctrl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]         out_rd,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [STALL_CNT_W-1:0]  stall_cnt
);

  localparam int PAYLOAD_W = LANES * DATA_W;

  // Every named control bit must fit inside the control field.
  if (CTRL_W <= CTRL_MEMWRITE || CTRL_W <= CTRL_MEMTOREG || CTRL_W <= CTRL_REGWRITE) begin : g_ctrl_w_check
    $error("CTRL_W is too narrow for the named control bits");
  end

  stage_state_e state_q, state_d;

  logic acc, con;
  logic main_load, skid_load, main_from_skid;

  logic [PAYLOAD_W-1:0] main_data, skid_data, main_data_in;
  logic [RD_W-1:0]      main_rd, skid_rd, main_rd_in;
  logic [CTRL_W-1:0]    main_ctrl, skid_ctrl, main_ctrl_in;

  logic [STALL_CNT_W-1:0] stall_q;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_TWO);

  assign acc = in_valid & in_ready;
  assign con = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && con) begin
          main_load = 1'b1;
        end else if (acc) begin
          skid_load = 1'b1;
          state_d   = ST_TWO;
        end else if (con) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (con) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    // Flush wins over any transfer; the payload registers keep their stale
    // contents since they are not presented once the stage is empty.
    if (flush) begin
      state_d        = ST_EMPTY;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  assign main_data_in = main_from_skid ? skid_data : in_data;
  assign main_rd_in   = main_from_skid ? skid_rd   : in_rd;
  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_entry #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .RD_W   (RD_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (main_load),
    .data_i (main_data_in),
    .rd_i   (main_rd_in),
    .ctrl_i (main_ctrl_in),
    .data_o (main_data),
    .rd_o   (main_rd),
    .ctrl_o (main_ctrl)
  );

  pipe_entry #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .RD_W   (RD_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (skid_load),
    .data_i (in_data),
    .rd_i   (in_rd),
    .ctrl_i (in_ctrl),
    .data_o (skid_data),
    .rd_o   (skid_rd),
    .ctrl_o (skid_ctrl)
  );

  assign out_data = main_data;
  assign out_rd   = main_rd;
  // A bubble must never carry MemWrite/RegWrite downstream.
  assign out_ctrl = out_valid ? main_ctrl : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_ex_mem_elastic_stage.sv
module tb_ex_mem_elastic_stage;

  localparam int DW = 64;
  localparam int LN = 3;
  localparam int RW = 5;
  localparam int CW = 3;
  localparam int SW = 16;
  localparam int PW = DW * LN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     = 1'b0;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [PW-1:0] in_data   = '0;
  logic [RW-1:0] in_rd     = '0;
  logic [CW-1:0] in_ctrl   = '0;

  logic          in_ready, out_valid;
  logic [PW-1:0] out_data;
  logic [RW-1:0] out_rd;
  logic [CW-1:0] out_ctrl;
  logic [SW-1:0] stall_cnt;

  logic          s_in_ready, s_out_valid;
  logic [PW-1:0] s_out_data;
  logic [RW-1:0] s_out_rd;
  logic [CW-1:0] s_out_ctrl;
  logic [3:0]    s_stall_cnt;

  ex_mem_elastic_stage #(
    .DATA_W(DW), .LANES(LN), .RD_W(RW), .CTRL_W(CW), .STALL_CNT_W(SW)
  ) dut (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy driven identically, used for saturation.
  ex_mem_elastic_stage #(
    .DATA_W(DW), .LANES(LN), .RD_W(RW), .CTRL_W(CW), .STALL_CNT_W(4)
  ) dut_sat (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_rd(s_out_rd), .out_ctrl(s_out_ctrl),
    .stall_cnt(s_stall_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two beats plus a stall tally.
  typedef struct {
    logic [PW-1:0] d;
    logic [RW-1:0] rd;
    logic [CW-1:0] c;
  } beat_t;

  beat_t mq[$];
  int    mcnt = 0;

  always @(posedge clk or negedge rst_n) begin
    int    n;
    bit    a, c;
    beat_t b;
    if (!rst_n) begin
      mq.delete();
      mcnt = 0;
    end else begin
      n = mq.size();
      a = in_valid && (n < 2);
      c = (n > 0) && out_ready;
      if (n > 0 && !out_ready) mcnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (c) void'(mq.pop_front());
        if (a) begin
          b.d = in_data; b.rd = in_rd; b.c = in_ctrl;
          mq.push_back(b);
        end
      end
    end
  end

  always @(negedge clk) begin
    bit v;
    int sat16, sat4;
    if (chk_en) begin
      v     = (mq.size() != 0);
      sat16 = (mcnt > 65535) ? 65535 : mcnt;
      sat4  = (mcnt > 15) ? 15 : mcnt;
      chk("cmp_out_valid", out_valid, v);
      chk("cmp_in_ready", in_ready, mq.size() < 2);
      chk("cmp_stall_cnt", stall_cnt, sat16);
      chk("cmp_sat_stall_cnt", s_stall_cnt, sat4);
      chk("cmp_sat_out_valid", s_out_valid, v);
      if (v) begin
        chk("cmp_out_data", out_data, mq[0].d);
        chk("cmp_out_rd", out_rd, mq[0].rd);
        chk("cmp_out_ctrl", out_ctrl, mq[0].c);
        chk("cmp_sat_out_data", s_out_data, mq[0].d);
      end else begin
        chk("cmp_bubble_ctrl", out_ctrl, '0);
        chk("cmp_sat_bubble_ctrl", s_out_ctrl, '0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [PW-1:0] d, input logic [RW-1:0] rd,
                       input logic [CW-1:0] c, input bit ordy, input bit fl);
    in_valid  = v;
    in_data   = d;
    in_rd     = rd;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  function automatic logic [PW-1:0] rnd_data();
    logic [PW-1:0] r;
    for (int i = 0; i < PW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_out_ctrl"}, out_ctrl, '0);
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_out_rd"}, out_rd, '0);
    chk({tag, "_stall_cnt"}, stall_cnt, '0);
    chk({tag, "_sat_stall_cnt"}, s_stall_cnt, '0);
  endtask

  initial begin
    int ordy_pct;

    #1;
    reset_checks("por");
    chk_en = 1'b1;
    step(); step();
    rst_n = 1'b1;

    // Streaming: one beat per cycle, each presented after the accepting edge.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, PW'(64'h10 * (i + 1)), RW'(i + 1), 3'b100, 1'b1, 1'b0);
      step();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_lane0", out_data[63:0], 64'h10 * (i + 1));
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();
    chk("stream_drained", out_valid, 1'b0);

    // Backpressure: three stalled cycles with in_valid held high.
    drive(1'b1, PW'(64'hA1), 5'd1, 3'b001, 1'b1, 1'b0);
    step();
    drive(1'b1, PW'(64'hA2), 5'd2, 3'b010, 1'b0, 1'b0);
    step();
    drive(1'b1, PW'(64'hA3), 5'd3, 3'b011, 1'b0, 1'b0);
    step();
    step();
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_stall_cnt", stall_cnt, 16'd3);
    chk("bp_head", out_data[63:0], 64'hA1);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();
    chk("bp_second", out_data[63:0], 64'hA2);
    chk("bp_second_valid", out_valid, 1'b1);
    step();
    chk("bp_empty", out_valid, 1'b0);

    // Flush in ST_TWO with a beat offered.
    drive(1'b1, PW'(64'hB1), 5'd4, 3'b100, 1'b0, 1'b0);
    step();
    drive(1'b1, PW'(64'hB2), 5'd5, 3'b100, 1'b0, 1'b0);
    step();
    chk("flush2_pre_ready", in_ready, 1'b0);
    drive(1'b1, PW'(64'hFF), 5'd6, 3'b101, 1'b0, 1'b1);
    step();
    chk("flush2_valid", out_valid, 1'b0);
    chk("flush2_ctrl", out_ctrl, 3'b000);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();
    chk("flush2_absent", out_valid, 1'b0);

    // Flush in ST_ONE: the offered beat would be accepted, but is dropped.
    drive(1'b1, PW'(64'hC1), 5'd7, 3'b100, 1'b0, 1'b0);
    step();
    drive(1'b1, PW'(64'hC2), 5'd8, 3'b101, 1'b0, 1'b1);
    step();
    chk("flush1_valid", out_valid, 1'b0);
    chk("flush1_ready", in_ready, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();

    // Bubble masking after a beat carrying all control bits.
    drive(1'b1, PW'(64'hD1), 5'd9, 3'b111, 1'b1, 1'b0);
    step();
    chk("bubble_beat_ctrl", out_ctrl, 3'b111);
    drive(1'b0, '0, '0, 3'b111, 1'b1, 1'b0);
    step();
    chk("bubble_valid", out_valid, 1'b0);
    chk("bubble_ctrl", out_ctrl, 3'b000);

    // Reset mid-operation with two beats held.
    drive(1'b1, PW'(64'hE1), 5'd10, 3'b111, 1'b0, 1'b0);
    step();
    drive(1'b1, PW'(64'hE2), 5'd11, 3'b111, 1'b0, 1'b0);
    step();
    chk("midrst_two_held", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step(); step();
    rst_n = 1'b1;

    // Saturation: one beat held for 20 stalled cycles.
    drive(1'b1, PW'(64'hF1), 5'd12, 3'b001, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    repeat (20) step();
    chk("sat_wide_cnt", stall_cnt, 16'd20);
    chk("sat_narrow_cnt", s_stall_cnt, 4'hF);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();

    // Randomized traffic with varying backpressure intensity.
    ordy_pct = 60;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 64 == 0) ordy_pct = $urandom_range(10, 100);
      drive(($urandom_range(0, 99) < 70), rnd_data(), RW'($urandom), CW'($urandom),
            ($urandom_range(0, 99) < ordy_pct), ($urandom_range(0, 99) < 3));
      step();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
